// File: rtl/rat_flag_file.sv
// RAT MCU status flag file with per-bit clear/set/load strobes
// and a shadow stack that saves flags on interrupt entry.
module rat_flag_file #(
  parameter  int NUM_FLAGS    = 2,
  parameter  int SHADOW_DEPTH = 1,
  localparam int DW           = $clog2(SHADOW_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [NUM_FLAGS-1:0] FLG_IN,
  input  logic [NUM_FLAGS-1:0] FLG_CLR,
  input  logic [NUM_FLAGS-1:0] FLG_SET,
  input  logic [NUM_FLAGS-1:0] FLG_LD,
  input  logic                 SHAD_PUSH,
  input  logic                 SHAD_POP,
  input  logic                 ERR_CLR,
  output logic [NUM_FLAGS-1:0] FLAGS,
  output logic [NUM_FLAGS-1:0] SHAD_TOP,
  output logic [DW-1:0]        DEPTH,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 ERR
);

  logic [NUM_FLAGS-1:0] r_flags;
  logic [NUM_FLAGS-1:0] r_stack [SHADOW_DEPTH];
  logic [DW-1:0]        r_depth;
  logic                 r_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_err_set;
  logic [NUM_FLAGS-1:0] w_top;
  logic [NUM_FLAGS-1:0] w_strobed;
  logic [NUM_FLAGS-1:0] w_flags_nxt;

  assign w_full  = (r_depth == DW'(SHADOW_DEPTH));
  assign w_empty = (r_depth == '0);

  assign w_push_ok = SHAD_PUSH & ~SHAD_POP & ~w_full;
  assign w_pop_ok  = SHAD_POP & ~SHAD_PUSH & ~w_empty;

  assign w_err_set = (SHAD_PUSH & SHAD_POP)
                   | (SHAD_PUSH & w_full)
                   | (SHAD_POP & w_empty);

  // Top of stack from registered state only; zero when empty.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (DW'(i + 1) == r_depth) begin
        w_top = r_stack[i];
      end
    end
  end

  // Per bit: CLR beats SET beats LD beats hold.
  assign w_strobed = ~FLG_CLR
                   & (FLG_SET
                      | (FLG_LD & FLG_IN)
                      | (~FLG_LD & r_flags));

  assign w_flags_nxt = w_pop_ok ? w_top : w_strobed;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_flags <= '0;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_flags_nxt;
      r_err   <= w_err_set | (r_err & ~ERR_CLR);
      if (w_push_ok) begin
        r_depth <= r_depth + DW'(1);
      end else if (w_pop_ok) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  // Push saves the pre-strobe flags; pop zeroes the vacated slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SHADOW_DEPTH; i++) begin
      if (RST) begin
        r_stack[i] <= '0;
      end else if (w_push_ok && (DW'(i) == r_depth)) begin
        r_stack[i] <= r_flags;
      end else if (w_pop_ok && (DW'(i + 1) == r_depth)) begin
        r_stack[i] <= '0;
      end
    end
  end

  assign FLAGS    = r_flags;
  assign SHAD_TOP = w_top;
  assign DEPTH    = r_depth;
  assign FULL     = w_full;
  assign EMPTY    = w_empty;
  assign ERR      = r_err;

endmodule

// File: tb/tb_rat_flag_file.sv
// Scoreboard bench for rat_flag_file (2 flags, 2-deep stack).
module tb_rat_flag_file;

  logic       clk = 1'b0;
  logic       RST;
  logic [1:0] FLG_IN, FLG_CLR, FLG_SET, FLG_LD;
  logic       SHAD_PUSH, SHAD_POP, ERR_CLR;
  logic [1:0] FLAGS, SHAD_TOP, DEPTH;
  logic       FULL, EMPTY, ERR;

  typedef struct {
    logic [1:0] flags;
    logic [1:0] top;
    logic [1:0] depth;
    logic       err;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  rat_flag_file #(.NUM_FLAGS(2), .SHADOW_DEPTH(2)) dut (
    .clk(clk), .RST(RST),
    .FLG_IN(FLG_IN), .FLG_CLR(FLG_CLR),
    .FLG_SET(FLG_SET), .FLG_LD(FLG_LD),
    .SHAD_PUSH(SHAD_PUSH), .SHAD_POP(SHAD_POP),
    .ERR_CLR(ERR_CLR),
    .FLAGS(FLAGS), .SHAD_TOP(SHAD_TOP),
    .DEPTH(DEPTH), .FULL(FULL), .EMPTY(EMPTY),
    .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, string fld,
                     logic [1:0] act, logic [1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %b, want %b",
                  nm, fld, act, req);
  endtask

  // Monitor: outputs are valid every cycle; compare after each edge.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "flags", FLAGS, e.flags);
      chk(e.name, "top", SHAD_TOP, e.top);
      chk(e.name, "depth", DEPTH, e.depth);
      chk(e.name, "full", {1'b0, FULL},
          {1'b0, e.depth == 2'd2});
      chk(e.name, "empty", {1'b0, EMPTY},
          {1'b0, e.depth == 2'd0});
      chk(e.name, "err", {1'b0, ERR}, {1'b0, e.err});
    end
  end

  task automatic step(
    input logic rst, input logic [1:0] in,
    input logic [1:0] clr, input logic [1:0] set,
    input logic [1:0] ld, input logic push,
    input logic pop, input logic eclr,
    input logic [1:0] ef, input logic [1:0] et,
    input logic [1:0] ed, input logic ee,
    input string nm);
    exp_t e;
    @(negedge clk);
    RST = rst; FLG_IN = in; FLG_CLR = clr;
    FLG_SET = set; FLG_LD = ld;
    SHAD_PUSH = push; SHAD_POP = pop; ERR_CLR = eclr;
    e.flags = ef; e.top = et; e.depth = ed;
    e.err = ee; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    RST = 1'b1; FLG_IN = '0; FLG_CLR = '0;
    FLG_SET = '0; FLG_LD = '0;
    SHAD_PUSH = 0; SHAD_POP = 0; ERR_CLR = 0;
    //   rst in   clr  set  ld   pu po ec  F    top  D    E
    step(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0,
         2'b00, 2'b00, 2'd0, 0, "reset");
    for (int i = 0; i < 5; i++)
      step(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0,
           2'b00, 2'b00, 2'd0, 0, "hold");
    step(0, 2'b00, 2'b01, 2'b11, 2'b10, 0, 0, 0,
         2'b10, 2'b00, 2'd0, 0, "prio");
    step(0, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0,
         2'b00, 2'b00, 2'd0, 0, "clr_all");
    step(0, 2'b11, 2'b00, 2'b00, 2'b01, 0, 0, 0,
         2'b01, 2'b00, 2'd0, 0, "ld_bit0");
    // save/restore
    step(0, 2'b00, 2'b00, 2'b10, 2'b00, 1, 0, 0,
         2'b11, 2'b01, 2'd1, 0, "push_set");
    step(0, 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0,
         2'b00, 2'b01, 2'd1, 0, "clr_nested");
    step(0, 2'b00, 2'b00, 2'b11, 2'b00, 0, 1, 0,
         2'b01, 2'b00, 2'd0, 0, "pop_wins");
    // nesting and overflow
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0,
         2'b01, 2'b01, 2'd1, 0, "nest_push1");
    step(0, 2'b10, 2'b00, 2'b00, 2'b11, 0, 0, 0,
         2'b10, 2'b01, 2'd1, 0, "nest_ld10");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0,
         2'b10, 2'b10, 2'd2, 0, "nest_push2");
    step(0, 2'b11, 2'b00, 2'b00, 2'b11, 0, 0, 0,
         2'b11, 2'b10, 2'd2, 0, "nest_ld11");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0,
         2'b11, 2'b10, 2'd2, 1, "overflow");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0,
         2'b10, 2'b01, 2'd1, 1, "nest_pop1");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0,
         2'b01, 2'b00, 2'd0, 1, "nest_pop2");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1,
         2'b01, 2'b00, 2'd0, 0, "err_clr");
    // errors
    step(0, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1, 0,
         2'b11, 2'b00, 2'd0, 1, "underflow");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1,
         2'b11, 2'b00, 2'd0, 0, "err_clr2");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0,
         2'b11, 2'b11, 2'd1, 0, "push_d1");
    step(0, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1, 0,
         2'b10, 2'b11, 2'd1, 1, "push_pop");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1,
         2'b10, 2'b11, 2'd1, 0, "err_clr3");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0,
         2'b11, 2'b00, 2'd0, 0, "pop_d1");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1,
         2'b11, 2'b00, 2'd0, 1, "clr_vs_set");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1,
         2'b11, 2'b00, 2'd0, 0, "err_clr4");
    // reset mid-nesting
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0,
         2'b11, 2'b11, 2'd1, 0, "rn_push1");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0,
         2'b11, 2'b11, 2'd2, 0, "rn_push2");
    step(1, 2'b11, 2'b00, 2'b11, 2'b11, 0, 1, 0,
         2'b00, 2'b00, 2'd0, 0, "rst_nest");
    step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0,
         2'b00, 2'b00, 2'd0, 1, "rst_underflow");
    @(negedge clk);
    SHAD_POP = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
